mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-005 SHALL have port is_write  input  1  1 = store, 0 = load; sampled with start.
REQ-006 SHALL have port size  input  2  00 word, 01 half, 10 byte, 11 reserved; sampled with start.
REQ-007 SHALL have port sign_ext  input  1  load extension, 1 = sign, 0 = zero; sampled with start.
REQ-008 SHALL have port addr  input  32  byte address from the IorD address mux; sampled with start.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned; sampled with start.
REQ-010 SHALL have port rdata  output  32  extended load result.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  alignment/size error, valid with done.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port mem_addr  output  32  word address {addr[31:2],2'b00} to memory.
REQ-015 SHALL have port mem_wr  output  1  memory write enable.
REQ-016 SHALL have port mem_wdata  output  32  word written to memory.
REQ-017 SHALL have port mem_rdata  input  32  memory read word, valid MEM_LAT cycles after mem_addr is presented.

Function
REQ-018 SHALL implement FSM states IDLE, RD_WAIT, RMW_WAIT, WR, DONE.
REQ-019 SHALL use little-endian lanes: byte k occupies bits 8k+7:8k; half at addr[1] = 0 occupies bits 15:0, at addr[1] = 1 bits 31:16.
REQ-020 SHALL treat these as misaligned: word with addr[1:0] != 0, half with addr[0] = 1, and size = 11; misaligned requests go IDLE->DONE, done = 1 and err = 1 at T+1, with no mem_wr and rdata unchanged.
REQ-021 SHALL, for a load accepted at cycle T, transition IDLE->RD_WAIT, hold RD_WAIT for MEM_LAT cycles, capture and extend mem_rdata on the last edge, then enter DONE, so done = 1 at T+MEM_LAT+1.
REQ-022 SHALL, for a word store accepted at T, transition IDLE->WR (mem_wr = 1, mem_wdata = wdata at T+1)->DONE, so done = 1 at T+2.
REQ-023 SHALL, for byte/half stores, perform read-modify-write: RMW_WAIT for MEM_LAT cycles, merge the store lane into the read word with all other lanes preserved, then WR, then DONE, so done = 1 at T+MEM_LAT+2.
REQ-024 SHALL drive mem_addr from latched addr during RD_WAIT, RMW_WAIT and WR, and SHALL drive mem_addr = 0 in IDLE and DONE.
REQ-025 SHALL assert mem_wr only when state = WR and reset = 0.
REQ-026 SHALL ignore start in every state other than IDLE; DONE always returns to IDLE after one cycle.
REQ-027 SHALL hold rdata from its capture edge until the next completed load; err SHALL be 0 except in the DONE cycle of an erroring request.
REQ-028 SHALL leave rdata unchanged on stores.

Reset
REQ-029 SHALL, on reset, set state = IDLE and rdata = 0; done, err, busy and mem_wr SHALL be 0 from the following cycle, and mem_addr SHALL be 0.
REQ-030 SHALL, when reset occurs mid-operation, including in WR, abandon the request with no done pulse and no write issued in the reset cycle.

Structure
REQ-031 SHALL place the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state enum in shared package cpu_mem_pkg.
REQ-032 SHALL factor lane extraction, extension and store merge into one combinational sub-module, mem_lane_unit.

Verification
REQ-033 Bench SHALL run an lb load with sign_ext = 1 at addr 0x00000013 where the word at 0x10 is 0x80FF1234 -> rdata = 0xFFFFFF80, done at T+2 (MEM_LAT = 1).
REQ-034 Bench SHALL run an lh load with sign_ext = 0 at addr 0x12 where the word at 0x10 is 0x80FF1234 -> rdata = 0x000080FF.
REQ-035 Bench SHALL run an sb store of wdata 0xAB at addr 0x21 where the word at 0x20 is 0x11223344 -> memory word 0x1122AB44, done at T+3, exactly one mem_wr cycle.
REQ-036 Bench SHALL run a sw store at addr 0x06 -> done = 1 and err = 1 at T+1, mem_wr never asserted.
REQ-037 Bench SHALL assert reset in the WR cycle of an sh store to 0x30 -> no write occurs, no done pulse, and busy = 0 on the next cycle.
REQ-038 Bench SHALL pulse start every cycle during a load with MEM_LAT = 3 -> only the first request is served, and done = 1 at T+4.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the load/store memory access path.
//   SZ_*           : access size encodings carried on the size port
//   mem_state_e    : sequencing states of mem_access_unit
//   is_misaligned  : alignment/size legality test for an incoming request
package cpu_mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        WR,
        DONE
    } mem_state_e;

    // Bytes are always aligned; the reserved size is rejected like a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_HALF: bad = addr_lo[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-side bus of mem_access_unit.
//   CPU side   : start, is_write, size, sign_ext, addr, wdata -> rdata, done, err, busy
//   memory side: mem_addr, mem_wr, mem_wdata -> mem_rdata
// slave  = the access unit; master = CPU plus memory environment driving it.
interface mem_access_unit_if;

    logic        start;
    logic        is_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, is_write, size, sign_ext, addr, wdata, mem_rdata,
        output rdata, done, err, busy, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output start, is_write, size, sign_ext, addr, wdata, mem_rdata,
        input  rdata, done, err, busy, mem_addr, mem_wr, mem_wdata
    );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic for sub-word accesses (little-endian lanes).
//   size, addr_lo, sign_ext : latched request attributes
//   rd_word                 : word read from memory
//   st_data                 : right-aligned store data
//   ld_data                 : selected lane, sign/zero extended to 32 bits
//   st_word                 : rd_word with the store lane(s) replaced
module mem_lane_unit
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [3:0]  lane_en;
    logic [31:0] st_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the store data across lanes lets every lane pick from the
    // same bit positions; lane_en decides which lanes actually take it.
    always_comb begin
        lane_en = 4'b1111;
        st_rep  = st_data;
        case (size)
            SZ_BYTE: begin
                lane_en = 4'b0001 << addr_lo;
                st_rep  = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                lane_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_rep  = {2{st_data[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                st_rep  = st_data;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign st_word[8*gi +: 8] = lane_en[gi] ? st_rep[8*gi +: 8] : rd_word[8*gi +: 8];
    end

    assign ld_byte = rd_word[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        case (size)
            SZ_BYTE: ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer between a CPU datapath and a word memory.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_access_unit_if.slave (CPU request/response + memory port)
// Loads wait MEM_LAT (1..4) cycles for mem_rdata, word stores write directly,
// byte/half stores read-modify-write. Misaligned requests finish next cycle
// with err.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_access_unit_if.slave bus
);

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    mem_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        sign_ext_q, sign_ext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;   // store data; becomes the merged word before WR
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        addr_phase;

    mem_lane_unit u_lane (
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .sign_ext (sign_ext_q),
        .rd_word  (bus.mem_rdata),
        .st_data  (wdata_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    size_d     = bus.size;
                    sign_ext_d = bus.sign_ext;
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    cnt_d      = LAT_LAST;
                    err_d      = is_misaligned(bus.size, bus.addr[1:0]);
                    if (err_d)
                        state_d = DONE;
                    else if (!bus.is_write)
                        state_d = RD_WAIT;
                    else if (bus.size == SZ_WORD)
                        state_d = WR;
                    else
                        state_d = RMW_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = ld_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RMW_WAIT: begin
                if (cnt_q == 2'd0) begin
                    wdata_d = st_word;
                    state_d = WR;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WR:   state_d = DONE;
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            size_q     <= SZ_WORD;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            sign_ext_q <= sign_ext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Gating with reset keeps a write in flight from reaching memory in the
    // very cycle the request is abandoned.
    assign addr_phase    = ((state_q == RD_WAIT) || (state_q == RMW_WAIT) || (state_q == WR)) && !reset;
    assign bus.mem_addr  = addr_phase ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_wr    = (state_q == WR) && !reset;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (MEM_LAT 1 and 3), each with a
// word memory and a request-level reference model checked every cycle, plus
// directed scenarios with hand-computed literal results.
`timescale 1ns/1ps
module tb_mem_access_unit;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic        start_s    [2];
    logic        is_write_s [2];
    logic        sign_ext_s [2];
    logic [1:0]  size_s     [2];
    logic [31:0] addr_s     [2];
    logic [31:0] wdata_s    [2];
    wire  [31:0] rdata_s    [2];
    wire         done_s     [2];
    wire         err_s      [2];
    wire         busy_s     [2];

    logic [31:0] ram     [2][64];
    logic [31:0] ref_mem [2][64];
    int done_total    [2] = '{0, 0};
    int wr_total      [2] = '{0, 0};
    int last_done_cyc [2] = '{0, 0};
    int last_done_err [2] = '{0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;
        localparam int PI  = (LAT > 1) ? LAT - 2 : 0;

        mem_access_unit_if bus ();
        logic [31:0] apipe [3];

        mem_access_unit #(.MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

        assign bus.start    = start_s[gi];
        assign bus.is_write = is_write_s[gi];
        assign bus.size     = size_s[gi];
        assign bus.sign_ext = sign_ext_s[gi];
        assign bus.addr     = addr_s[gi];
        assign bus.wdata    = wdata_s[gi];
        assign rdata_s[gi]  = bus.rdata;
        assign done_s[gi]   = bus.done;
        assign err_s[gi]    = bus.err;
        assign busy_s[gi]   = bus.busy;

        // Memory: read data reflects the address presented LAT-1 cycles earlier.
        assign bus.mem_rdata = (LAT == 1) ? ram[gi][bus.mem_addr[7:2]] : ram[gi][apipe[PI][7:2]];

        always @(posedge clk) begin
            apipe[2] <= apipe[1];
            apipe[1] <= apipe[0];
            apipe[0] <= bus.mem_addr;
            if (bus.mem_wr === 1'b1) ram[gi][bus.mem_addr[7:2]] = bus.mem_wdata;
        end

        // Request-level model: one outstanding request, with completion and
        // write cycles computed from the latency rules at acceptance time.
        bit          active = 1'b0;
        bit          mis_f  = 1'b0;
        bit          is_ld  = 1'b0;
        int          done_c = 0;
        int          wr_c   = -1;
        logic [31:0] wa, wdat, ld_val, rd_exp;

        always @(posedge clk) begin : model
            logic [31:0] w, mask;
            int sh;
            if (reset) begin
                active = 1'b0;
                rd_exp = 32'h0;
            end else begin
                if (active && cyc == wr_c) ref_mem[gi][wa[7:2]] = wdat;
                if (active && is_ld && cyc + 1 == done_c) rd_exp = ld_val;
                if (active && cyc == done_c) begin
                    active = 1'b0;
                end else if (!active && start_s[gi]) begin
                    active = 1'b1;
                    wa     = addr_s[gi];
                    w      = ref_mem[gi][wa[7:2]];
                    is_ld  = !is_write_s[gi];
                    mis_f  = (size_s[gi] == 2'b11) || (size_s[gi] == SZ_WORD && wa[1:0] != 2'b00)
                             || (size_s[gi] == SZ_HALF && wa[0]);
                    wr_c   = -1;
                    if (size_s[gi] == SZ_BYTE) begin
                        sh = 8 * int'(wa[1:0]);
                        mask = 32'hFF << sh;
                    end else if (size_s[gi] == SZ_HALF) begin
                        sh = 16 * int'(wa[1]);
                        mask = 32'hFFFF << sh;
                    end else begin
                        sh = 0;
                        mask = 32'hFFFF_FFFF;
                    end
                    ld_val = (w & mask) >> sh;
                    if (sign_ext_s[gi] && size_s[gi] == SZ_BYTE && ld_val[7])  ld_val = ld_val | 32'hFFFF_FF00;
                    if (sign_ext_s[gi] && size_s[gi] == SZ_HALF && ld_val[15]) ld_val = ld_val | 32'hFFFF_0000;
                    wdat = (w & ~mask) | ((wdata_s[gi] << sh) & mask);
                    if (mis_f) begin
                        is_ld  = 1'b0;
                        done_c = cyc + 1;
                    end else if (is_ld) begin
                        done_c = cyc + LAT + 1;
                    end else if (size_s[gi] == SZ_WORD) begin
                        wr_c   = cyc + 1;
                        done_c = cyc + 2;
                    end else begin
                        wr_c   = cyc + LAT + 1;
                        done_c = cyc + LAT + 2;
                    end
                end
            end
        end

        always @(negedge clk) begin : cmp
            bit e_done;
            if (bus.done === 1'b1) begin
                done_total[gi]++;
                last_done_cyc[gi] = cyc;
                last_done_err[gi] = int'(bus.err);
            end
            if (bus.mem_wr === 1'b1) wr_total[gi]++;
            if (chk_en) begin
                if (reset) begin
                    check($sformatf("u%0d mem_wr in reset", gi), bus.mem_wr, 0);
                    check($sformatf("u%0d mem_addr in reset", gi), bus.mem_addr, 0);
                end else begin
                    e_done = active && cyc == done_c;
                    check($sformatf("u%0d done", gi), bus.done, e_done);
                    check($sformatf("u%0d err", gi), bus.err, e_done && mis_f);
                    check($sformatf("u%0d busy", gi), bus.busy, active);
                    check($sformatf("u%0d mem_wr", gi), bus.mem_wr, active && cyc == wr_c);
                    check($sformatf("u%0d mem_addr", gi), bus.mem_addr,
                          (active && !mis_f && cyc < done_c) ? {wa[31:2], 2'b00} : 32'h0);
                    check($sformatf("u%0d rdata", gi), bus.rdata, rd_exp);
                    if (active && cyc == wr_c)
                        check($sformatf("u%0d mem_wdata", gi), bus.mem_wdata, wdat);
                end
            end
        end
    end

    task automatic preload(input int i, input logic [31:0] a, input logic [31:0] v);
        ram[i][a[7:2]]     = v;
        ref_mem[i][a[7:2]] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; t returns its acceptance cycle.
    task automatic req(input int i, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, output int t);
        t = cyc;
        start_s[i] = 1'b1; is_write_s[i] = w; size_s[i] = sz;
        sign_ext_s[i] = sx; addr_s[i] = a; wdata_s[i] = wd;
        idle(1);
        start_s[i] = 1'b0;
        addr_s[i]  = {24'h0, 8'($urandom)};
        wdata_s[i] = $urandom;
        size_s[i]  = 2'($urandom_range(0, 3));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t, w0, d0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; is_write_s[i] = 1'b0; sign_ext_s[i] = 1'b0;
            size_s[i] = SZ_WORD; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
            for (int k = 0; k < 64; k++) preload(i, 32'(k * 4), $urandom);
        end
        idle(2);
        chk_en = 1'b1;
        check("reset rdata", rdata_s[0], 32'h0);
        check("reset busy", busy_s[1], 1'b0);
        check("reset done", done_s[0], 1'b0);
        reset = 1'b0;
        idle(1);

        // lb, sign extended, top byte of 0x80FF1234
        preload(0, 32'h10, 32'h80FF1234);
        req(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, t);
        idle(4);
        check("lb rdata", rdata_s[0], 32'hFFFF_FF80);
        check("lb done latency", last_done_cyc[0] - t, 2);

        // lh, zero extended, upper half
        req(0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, t);
        idle(4);
        check("lh rdata", rdata_s[0], 32'h0000_80FF);

        // sb read-modify-write
        preload(0, 32'h20, 32'h11223344);
        w0 = wr_total[0];
        req(0, 1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000_00AB, t);
        idle(4);
        check("sb memory word", ram[0][8], 32'h1122_AB44);
        check("sb done latency", last_done_cyc[0] - t, 3);
        check("sb write count", wr_total[0] - w0, 1);
        check("sb rdata kept", rdata_s[0], 32'h0000_80FF);

        // misaligned sw
        w0 = wr_total[0];
        req(0, 1'b1, SZ_WORD, 1'b0, 32'h06, 32'hDEAD_BEEF, t);
        idle(3);
        check("sw misaligned latency", last_done_cyc[0] - t, 1);
        check("sw misaligned err", last_done_err[0], 1);
        check("sw misaligned writes", wr_total[0] - w0, 0);

        // reset during the WR cycle of an sh
        preload(0, 32'h30, 32'hCAFE_F00D);
        w0 = wr_total[0];
        d0 = done_total[0];
        req(0, 1'b1, SZ_HALF, 1'b0, 32'h30, 32'h0000_5555, t);
        idle(1);
        check("sh in WR busy", busy_s[0], 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("sh abort busy", busy_s[0], 1'b0);
        idle(3);
        check("sh abort memory", ram[0][12], 32'hCAFE_F00D);
        check("sh abort writes", wr_total[0] - w0, 0);
        check("sh abort done", done_total[0] - d0, 0);

        // MEM_LAT = 3 load with start held high through the whole operation
        preload(1, 32'h40, 32'h89AB_CDEF);
        preload(1, 32'h44, 32'h0102_0304);
        d0 = done_total[1];
        t = cyc;
        start_s[1] = 1'b1; is_write_s[1] = 1'b0; size_s[1] = SZ_WORD;
        sign_ext_s[1] = 1'b0; addr_s[1] = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            addr_s[1] = 32'h44;
        end
        start_s[1] = 1'b0;
        idle(3);
        check("lat3 done count", done_total[1] - d0, 1);
        check("lat3 done latency", last_done_cyc[1] - t, 4);
        check("lat3 rdata", rdata_s[1], 32'h89AB_CDEF);

        // randomized traffic on both instances, with occasional resets
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 2; i++) begin
                start_s[i]    = ($urandom_range(0, 2) == 0);
                is_write_s[i] = 1'($urandom_range(0, 1));
                size_s[i]     = 2'($urandom_range(0, 3));
                sign_ext_s[i] = 1'($urandom_range(0, 1));
                addr_s[i]     = {24'h0, 8'($urandom)};
                wdata_s[i]    = $urandom;
            end
            reset = ($urandom_range(0, 149) == 0);
            idle(1);
        end
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        reset = 1'b0;
        idle(10);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++)
                check($sformatf("u%0d final mem[%0d]", i, k), ram[i][k], ref_mem[i][k]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
